seq_tail_light_ctrl: RTL and testbench
======================================

# seq_tail_light_ctrl

Parametrised sequential tail-light controller for the vehicle lighting subsystem. It drives N lamps per side with a configurable step period, and generates left/right sequential sweeps, steady brake lighting and an optional hazard flash. It sits between the debounced driver-input block and the lamp driver stage, and all of its outputs are registered.

## Interface
- N_LAMPS, 3, lamps per side; legal range 1..16; bit 0 is the innermost lamp.
- STEP_CYCLES, 4, clock cycles each sweep/flash step is held; legal range ≥1.
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- brake  input  1  brake pedal request, level.
- turn_left  input  1  left indicator request, level.
- turn_right  input  1  right indicator request, level.
- hazard  input  1  hazard request, level. Present only with TLC_HAZARD_EN.
- left_lamps  output  N_LAMPS  left lamp enables, 1 = lit.
- right_lamps  output  N_LAMPS  right lamp enables, 1 = lit.
- mode  output  2  current mode: IDLE=0, LEFT=1, RIGHT=2, HAZARD=3.

## Operation
- The FSM has four states: IDLE, LEFT, RIGHT and HAZARD.
- Requested state, in priority order:
  - HAZARD when hazard=1.
  - LEFT when turn_left=1 and turn_right=0.
  - RIGHT when turn_right=1 and turn_left=0.
  - IDLE otherwise. Both turn inputs high without hazard gives IDLE.
- The FSM moves to the requested state on every edge. Any state change clears the prescaler and the step counter.
- Step counter `step`:
  - Width $clog2(N_LAMPS+1).
  - Advances on each prescaler tick.
  - Sequence is 1,2,…,N_LAMPS,0,1,… and wraps from N_LAMPS to 0.
  - Entering LEFT or RIGHT loads step=1.
- Sweep pattern at step s: lamps[s-1:0]=1, all other lamps 0; s=0 means all off. For N_LAMPS=3 the pattern is 001, 011, 111, 000, repeating.
- Turning side shows the sweep pattern. Brake has no effect on the turning side.
- Non-turning side shows all ones when brake=1 and all zeros otherwise.
- IDLE: both sides show all ones when brake=1 and all zeros otherwise.
- HAZARD:
  - Both sides flash in phase: all ones for STEP_CYCLES cycles, then all zeros for STEP_CYCLES cycles, starting with ones.
  - Brake is ignored in this state.
  - The flash phase is bit 0 of the step counter, which toggles on each tick in this state.
- Prescaler:
  - Width $clog2(STEP_CYCLES), or 1 bit minimum.
  - Counts 0..STEP_CYCLES-1 and asserts a tick in the last count.
  - With STEP_CYCLES=1 it ticks every cycle.
- Brake changes while the FSM stays in the same state do not restart the sweep.

## Timing
- Reset (async assert): left_lamps=0, right_lamps=0, mode=IDLE, step=0, prescaler=0.
- Reset release: outputs follow inputs from the first rising edge after rst_n rises. Reset asserted mid-sweep clears everything immediately, without waiting for a clock edge.
- Latency: inputs sampled at edge k produce the new mode and first pattern at edge k (registered outputs) and hold them for STEP_CYCLES cycles. Each following step also lasts exactly STEP_CYCLES cycles.
- Sweep period is (N_LAMPS+1)·STEP_CYCLES cycles. Hazard period is 2·STEP_CYCLES cycles.
- Simultaneous events:
  - Any request change at the same edge as a tick: the state change wins, and the counters reload rather than advance.
  - Direct LEFT↔RIGHT switch: the old side drops to its brake/off level on the same edge.

## Configuration
- TLC_HAZARD_EN defined:
  - The hazard port exists.
  - HAZARD is reachable, with highest priority.
- TLC_HAZARD_EN undefined:
  - There is no hazard port.
  - HAZARD is unreachable, and mode never reports 3.
  - All other behaviour is identical.

## Structure
- Package tlc_pkg holds:
  - the mode enum (IDLE, LEFT, RIGHT, HAZARD, 2 bits);
  - a function sweep_pattern(step, N) that returns the lamp vector.
- Sub-module step_prescaler:
  - Parameter STEP_CYCLES.
  - Inputs clk, rst_n, clr.
  - Output tick.
  - Top level instantiates one.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
- Reset mid-sweep (N_LAMPS=3, STEP_CYCLES=4, turn_left=1 for 6 cycles, then rst_n=0) → both sides read 000 immediately; mode=0.
- turn_right=1, brake=0, defaults → right_lamps 001, 011, 111, 000, held 4 cycles each and repeating; left_lamps=000; mode=2.
- turn_left=1 with brake=1 → left_lamps sweeps; right_lamps=111 constant. Toggling brake mid-sweep does not restart the sweep.
- brake=1 only, then both turns=1 with brake=1 → both sides 111 and mode=0 in both cases.
- Switch turn_left→turn_right on a tick edge with STEP_CYCLES=1, N_LAMPS=5 → left_lamps=0 and right_lamps=00001 at that edge; sweep then advances every cycle.
- TLC_HAZARD_EN, hazard=1 with turn_left=1 and brake=1 → mode=3; both sides 111 for 4 cycles, then 000 for 4 cycles, repeating.

Source files
------------

// File: rtl/seq_tail_light_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | tlc_pkg: mode encoding and sweep-pattern helper for the tail-light ctrl  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package tlc_pkg;

    localparam int C_MAX_LAMPS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } mode_t;

    // The lowest `step` lamps are lit, capped at n; step 0 is all off.
    function automatic logic [C_MAX_LAMPS-1:0] sweep_pattern(input logic [4:0] step,
                                                             input int         n);
        logic [C_MAX_LAMPS-1:0] pat;
        for (int i = 0; i < C_MAX_LAMPS; i++) begin
            pat[i] = (i < int'(step)) && (i < n);
        end
        return pat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_tail_light_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | seq_tail_light_ctrl_if: driver requests in, lamp enables and mode out    |
// | hazard exists only when TLC_HAZARD_EN is defined.  Revision: 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

interface seq_tail_light_ctrl_if #(
    parameter int N_LAMPS = 3
);
    logic                 brake;
    logic                 turn_left;
    logic                 turn_right;
`ifdef TLC_HAZARD_EN
    logic                 hazard;
`endif
    logic [N_LAMPS-1:0]   left_lamps;
    logic [N_LAMPS-1:0]   right_lamps;
    tlc_pkg::mode_t       mode;

`ifdef TLC_HAZARD_EN
    modport master (output brake, turn_left, turn_right, hazard,
                    input  left_lamps, right_lamps, mode);
    modport slave  (input  brake, turn_left, turn_right, hazard,
                    output left_lamps, right_lamps, mode);
`else
    modport master (output brake, turn_left, turn_right,
                    input  left_lamps, right_lamps, mode);
    modport slave  (input  brake, turn_left, turn_right,
                    output left_lamps, right_lamps, mode);
`endif

endinterface

`default_nettype wire

// File: rtl/seq_tail_light_ctrl_step_prescaler.sv
// +--------------------------------------------------------------------------+
// | step_prescaler: counts 0..STEP_CYCLES-1, tick in the last count          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module step_prescaler #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int                 c_cnt_w = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(STEP_CYCLES - 1);

    generate
        if (STEP_CYCLES < 1) begin : g_bad_step_cycles
            $error("step_prescaler: STEP_CYCLES must be >= 1");
        end
    endgenerate

    logic [c_cnt_w-1:0] r_cnt;

    assign tick = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_tail_light_ctrl.sv
// +--------------------------------------------------------------------------+
// | seq_tail_light_ctrl: sequential sweep / brake / hazard tail-light ctrl   |
// | Optional hazard flash with TLC_HAZARD_EN.  Revision: 1.0                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_tail_light_ctrl
    import tlc_pkg::*;
#(
    parameter int N_LAMPS     = 3,
    parameter int STEP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_tail_light_ctrl_if.slave  bus
);
    localparam int                 c_step_w = $clog2(N_LAMPS + 1);
    localparam logic [N_LAMPS-1:0] c_all_on = '1;

    generate
        if (N_LAMPS < 1 || N_LAMPS > C_MAX_LAMPS) begin : g_bad_n_lamps
            $error("seq_tail_light_ctrl: N_LAMPS must be in 1..16");
        end
        if (STEP_CYCLES < 1) begin : g_bad_step_cycles
            $error("seq_tail_light_ctrl: STEP_CYCLES must be >= 1");
        end
    endgenerate

    mode_t               r_state;
    logic [c_step_w-1:0] r_step;
    logic [N_LAMPS-1:0]  r_left;
    logic [N_LAMPS-1:0]  r_right;

    mode_t               w_req;
    logic                w_change;
    logic                w_tick;
    logic [c_step_w-1:0] w_next_step;
    logic [N_LAMPS-1:0]  w_sweep;
    logic [N_LAMPS-1:0]  w_flash;
    logic [N_LAMPS-1:0]  w_brake_lvl;
    logic [N_LAMPS-1:0]  w_left_nxt;
    logic [N_LAMPS-1:0]  w_right_nxt;

    // Later assignments override earlier ones, giving hazard top priority.
    always_comb begin
        w_req = IDLE;
        if (bus.turn_left && !bus.turn_right) begin
            w_req = LEFT;
        end else if (bus.turn_right && !bus.turn_left) begin
            w_req = RIGHT;
        end
`ifdef TLC_HAZARD_EN
        if (bus.hazard) begin
            w_req = HAZARD;
        end
`endif
    end

    assign w_change = (w_req != r_state);

    step_prescaler #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_change),
        .tick  (w_tick)
    );

    // A state change reloads the step even when it coincides with a tick.
    always_comb begin
        w_next_step = r_step;
        if (w_change) begin
            w_next_step = (w_req == LEFT || w_req == RIGHT) ? c_step_w'(1) : '0;
        end else if (w_tick) begin
            case (r_state)
                LEFT, RIGHT: w_next_step = (r_step == c_step_w'(N_LAMPS)) ? '0
                                                                          : r_step + 1'b1;
                HAZARD:      w_next_step = r_step ^ c_step_w'(1);
                default:     w_next_step = r_step;
            endcase
        end
    end

    assign w_sweep     = N_LAMPS'(sweep_pattern(5'(w_next_step), N_LAMPS));
    assign w_flash     = w_next_step[0] ? '0 : c_all_on;
    assign w_brake_lvl = bus.brake ? c_all_on : '0;

    always_comb begin
        w_left_nxt  = w_brake_lvl;
        w_right_nxt = w_brake_lvl;
        case (w_req)
            LEFT:    w_left_nxt  = w_sweep;
            RIGHT:   w_right_nxt = w_sweep;
            HAZARD: begin
                w_left_nxt  = w_flash;
                w_right_nxt = w_flash;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_left  <= '0;
            r_right <= '0;
        end else begin
            r_state <= w_req;
            r_step  <= w_next_step;
            r_left  <= w_left_nxt;
            r_right <= w_right_nxt;
        end
    end

    assign bus.left_lamps  = r_left;
    assign bus.right_lamps = r_right;
    assign bus.mode        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_seq_tail_light_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_seq_tail_light_ctrl: two instances (3 lamps/4 cycles, 5 lamps/1 cyc)  |
// | Hazard stimulus only when TLC_HAZARD_EN is defined.  Revision: 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seq_tail_light_ctrl;

    localparam int NA = 3;
    localparam int SA = 4;
    localparam int NB = 5;
    localparam int SB = 1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_tail_light_ctrl_if #(.N_LAMPS(NA)) bus_a ();
    seq_tail_light_ctrl_if #(.N_LAMPS(NB)) bus_b ();

    seq_tail_light_ctrl #(.N_LAMPS(NA), .STEP_CYCLES(SA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    seq_tail_light_ctrl #(.N_LAMPS(NB), .STEP_CYCLES(SB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    logic hz_a, hz_b;
`ifdef TLC_HAZARD_EN
    assign hz_a = bus_a.hazard;
    assign hz_b = bus_b.hazard;
`else
    assign hz_a = 1'b0;
    assign hz_b = 1'b0;
`endif

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int req_of(input logic l, input logic r, input logic h);
        if (h)       return 3;
        if (l && !r) return 1;
        if (r && !l) return 2;
        return 0;
    endfunction

    // Expected lamps for one side, t cycles after the mode was entered.
    function automatic logic [15:0] side_exp(input int st, input int side, input int t,
                                             input logic brk, input int n, input int s);
        logic [15:0] all_on;
        int          k;
        all_on = 16'((32'd1 << n) - 1);
        if (st == 3) return (((t / s) % 2) == 0) ? all_on : 16'h0;
        if (st == side) begin
            k = ((t / s) + 1) % (n + 1);
            return 16'((32'd1 << k) - 1);
        end
        return brk ? all_on : 16'h0;
    endfunction

    int   a_st = 0, a_t = 0, b_st = 0, b_t = 0;
    logic a_brk, b_brk, a_rs, b_rs;
    int   a_req, b_req;

    always @(posedge clk) begin
        a_rs  = rst_n;
        a_brk = bus_a.brake;
        a_req = req_of(bus_a.turn_left, bus_a.turn_right, hz_a);
        #1;
        if (!a_rs) begin
            a_st = 0; a_t = 0;
            check("a_rst_left", 16'(bus_a.left_lamps), 16'h0);
            check("a_rst_right", 16'(bus_a.right_lamps), 16'h0);
        end else begin
            if (a_req != a_st) begin a_st = a_req; a_t = 0; end
            else a_t++;
            check("a_left", 16'(bus_a.left_lamps), side_exp(a_st, 1, a_t, a_brk, NA, SA));
            check("a_right", 16'(bus_a.right_lamps), side_exp(a_st, 2, a_t, a_brk, NA, SA));
        end
        check("a_mode", 16'(bus_a.mode), 16'(a_st));
    end

    always @(posedge clk) begin
        b_rs  = rst_n;
        b_brk = bus_b.brake;
        b_req = req_of(bus_b.turn_left, bus_b.turn_right, hz_b);
        #1;
        if (!b_rs) begin
            b_st = 0; b_t = 0;
            check("b_rst_left", 16'(bus_b.left_lamps), 16'h0);
            check("b_rst_right", 16'(bus_b.right_lamps), 16'h0);
        end else begin
            if (b_req != b_st) begin b_st = b_req; b_t = 0; end
            else b_t++;
            check("b_left", 16'(bus_b.left_lamps), side_exp(b_st, 1, b_t, b_brk, NB, SB));
            check("b_right", 16'(bus_b.right_lamps), side_exp(b_st, 2, b_t, b_brk, NB, SB));
        end
        check("b_mode", 16'(bus_b.mode), 16'(b_st));
    end

    task automatic lit_a(input string name, input logic [15:0] l, input logic [15:0] r,
                         input logic [15:0] m);
        check({name, "_left"}, 16'(bus_a.left_lamps), l);
        check({name, "_right"}, 16'(bus_a.right_lamps), r);
        check({name, "_mode"}, 16'(bus_a.mode), m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus_a.brake = 0; bus_a.turn_left = 0; bus_a.turn_right = 0;
        bus_b.brake = 0; bus_b.turn_left = 0; bus_b.turn_right = 0;
`ifdef TLC_HAZARD_EN
        bus_a.hazard = 0; bus_b.hazard = 0;
`endif
        repeat (2) @(negedge clk);
        lit_a("reset", 16'h0, 16'h0, 16'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Right sweep: 001, 011, 111, 000, 001, 4 cycles each
        bus_a.turn_right = 1;
        @(negedge clk);     lit_a("r_s1", 16'b000, 16'b001, 16'd2);
        repeat (4) @(negedge clk); lit_a("r_s2", 16'b000, 16'b011, 16'd2);
        repeat (4) @(negedge clk); lit_a("r_s3", 16'b000, 16'b111, 16'd2);
        repeat (4) @(negedge clk); lit_a("r_s0", 16'b000, 16'b000, 16'd2);
        repeat (4) @(negedge clk); lit_a("r_wrap", 16'b000, 16'b001, 16'd2);

        // Direct switch to left with brake; brake toggles mid-sweep
        bus_a.turn_right = 0; bus_a.turn_left = 1; bus_a.brake = 1;
        @(negedge clk);     lit_a("lb_s1", 16'b001, 16'b111, 16'd1);
        repeat (5) @(negedge clk);
        bus_a.brake = 0;
        @(negedge clk);     lit_a("lb_nobrk", 16'b011, 16'b000, 16'd1);
        repeat (2) @(negedge clk); lit_a("lb_s3", 16'b111, 16'b000, 16'd1);
        bus_a.brake = 1;
        repeat (8) @(negedge clk);

        // Asynchronous reset mid-sweep
        bus_a.turn_left = 0; bus_a.brake = 0;
        repeat (2) @(negedge clk);
        bus_a.turn_left = 1;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 lit_a("async_rst", 16'h0, 16'h0, 16'd0);
        repeat (2) @(negedge clk);
        bus_a.turn_left = 0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Brake only, then both turns with brake
        bus_a.brake = 1;
        @(negedge clk);     lit_a("brake_only", 16'b111, 16'b111, 16'd0);
        bus_a.turn_left = 1; bus_a.turn_right = 1;
        @(negedge clk);     lit_a("both_turns", 16'b111, 16'b111, 16'd0);
        repeat (3) @(negedge clk);
        bus_a.turn_left = 0; bus_a.turn_right = 0; bus_a.brake = 0;
        repeat (2) @(negedge clk);

`ifdef TLC_HAZARD_EN
        bus_a.hazard = 1; bus_a.turn_left = 1; bus_a.brake = 1;
        @(negedge clk);     lit_a("hz_on", 16'b111, 16'b111, 16'd3);
        repeat (4) @(negedge clk); lit_a("hz_off", 16'b000, 16'b000, 16'd3);
        repeat (4) @(negedge clk); lit_a("hz_on2", 16'b111, 16'b111, 16'd3);
        repeat (6) @(negedge clk);
        bus_a.hazard = 0; bus_a.turn_left = 0; bus_a.brake = 0;
        repeat (2) @(negedge clk);
`endif

        // 5 lamps, 1-cycle steps: left to right switch on a tick edge
        bus_b.turn_left = 1;
        repeat (4) @(negedge clk);
        check("b_pre_left", 16'(bus_b.left_lamps), 16'b01111);
        bus_b.turn_left = 0; bus_b.turn_right = 1;
        @(negedge clk);
        check("b_sw_left", 16'(bus_b.left_lamps), 16'b00000);
        check("b_sw_right", 16'(bus_b.right_lamps), 16'b00001);
        check("b_sw_mode", 16'(bus_b.mode), 16'd2);
        @(negedge clk);
        check("b_next_right", 16'(bus_b.right_lamps), 16'b00011);
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
